// File: rtl/pytxaclbufctrl_pkg.sv
// Shared widths and helpers for the Tx ACL ping-pong payload buffer.
package pytxaclbufctrl_pkg;
  localparam int AW            = 8;
  localparam int DW            = 32;
  localparam int LENW          = 10;
  localparam int BANK_WORDS    = 128;
  localparam int MAX_ACL_BYTES = 339;

  typedef logic [AW-2:0] woff_t;

  localparam woff_t WPTR_LAST = woff_t'(BANK_WORDS - 1);

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_e;

  function automatic logic [AW-1:0] bank_addr(input logic bank, input woff_t off);
    return {bank, off};
  endfunction
endpackage

// File: rtl/pytxaclbufctrl_if.sv
// Link-controller write side and bsm read side of the Tx ACL buffer.
interface pytxaclbufctrl_if;
  import pytxaclbufctrl_pkg::*;

  logic            lnctrl_wr;
  logic [DW-1:0]   lnctrl_wdata;
  logic            lnctrl_commit;
  logic [LENW-1:0] lnctrl_len;
  logic            lnctrl_wready;
  logic            lnctrl_bufavail;
  logic            lnctrl_ovf;
  logic            bsm_rd;
  logic [AW-2:0]   bsm_addr;
  logic [DW-1:0]   bsm_dout;
  logic            bsm_dout_valid;
  logic            bsm_pkt_valid;
  logic [LENW-1:0] bsm_pkt_len;
  logic            bsm_ack;
  logic            bsm_flush;

  modport master (
    output lnctrl_wr, lnctrl_wdata, lnctrl_commit, lnctrl_len,
    input  lnctrl_wready, lnctrl_bufavail, lnctrl_ovf,
    output bsm_rd, bsm_addr, bsm_ack, bsm_flush,
    input  bsm_dout, bsm_dout_valid, bsm_pkt_valid, bsm_pkt_len
  );

  modport slave (
    input  lnctrl_wr, lnctrl_wdata, lnctrl_commit, lnctrl_len,
    output lnctrl_wready, lnctrl_bufavail, lnctrl_ovf,
    input  bsm_rd, bsm_addr, bsm_ack, bsm_flush,
    output bsm_dout, bsm_dout_valid, bsm_pkt_valid, bsm_pkt_len
  );
endinterface

// File: rtl/pytxaclbufctrl_sram256x32_1p.sv
// Single-port 256x32 SRAM, registered read; contents are never reset.
module sram256x32_1p
  import pytxaclbufctrl_pkg::*;
(
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        mem[a] <= din;
      end else begin
        dout <= mem[a];
      end
    end
  end
endmodule

// File: rtl/pytxaclbufctrl.sv
// Tx ACL ping-pong buffer: writer fills one bank while the bsm re-reads the other until ACKed.
module pytxaclbufctrl
  import pytxaclbufctrl_pkg::*;
(
  input  logic           clk_6M,
  input  logic           rstz,
  pytxaclbufctrl_if.slave bus
);
  acc_e            acc;
  logic            wr_bank_reg;
  logic            rd_bank_reg;
  logic            ovf_reg;
  logic            dout_valid_reg;
  woff_t           wptr_reg;
  logic [1:0]      full;
  logic [LENW-1:0] bank_len [2];
  logic            bufavail;
  logic            wready;
  logic            commit_ok;
  logic            ack_ok;
  logic            sram_cs;
  logic            sram_we;
  logic [AW-1:0]   sram_a;

  assign bufavail  = ~full[wr_bank_reg];
  assign wready    = bufavail & ~bus.bsm_rd & ~ovf_reg;
  assign commit_ok = bus.lnctrl_commit & bufavail;
  assign ack_ok    = bus.bsm_ack & full[rd_bank_reg];

  // The single SRAM port always goes to the bsm first; the writer retries.
  always_comb begin
    acc     = ACC_IDLE;
    sram_cs = 1'b0;
    sram_we = 1'b0;
    sram_a  = '0;
    if (bus.bsm_rd) begin
      acc     = ACC_RD;
      sram_cs = 1'b1;
      sram_a  = bank_addr(rd_bank_reg, bus.bsm_addr);
    end else if (bus.lnctrl_wr && wready) begin
      acc     = ACC_WR;
      sram_cs = 1'b1;
      sram_we = 1'b1;
      sram_a  = bank_addr(wr_bank_reg, wptr_reg);
    end
  end

  sram256x32_1p u_sram (
    .clk  (clk_6M),
    .cs   (sram_cs),
    .we   (sram_we),
    .a    (sram_a),
    .din  (bus.lnctrl_wdata),
    .dout (bus.bsm_dout)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      wptr_reg       <= '0;
      ovf_reg        <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= bus.bsm_rd;
      if (bus.bsm_flush) begin
        wr_bank_reg <= 1'b0;
        rd_bank_reg <= 1'b0;
        wptr_reg    <= '0;
        ovf_reg     <= 1'b0;
      end else begin
        // The last word of a bank is stored, then the pointer parks and ovf blocks further writes.
        if (acc == ACC_WR) begin
          if (wptr_reg == WPTR_LAST) begin
            ovf_reg <= 1'b1;
          end else begin
            wptr_reg <= wptr_reg + 1'b1;
          end
        end
        if (commit_ok) begin
          wr_bank_reg <= ~wr_bank_reg;
          wptr_reg    <= '0;
          ovf_reg     <= 1'b0;
        end
        if (ack_ok) begin
          rd_bank_reg <= ~rd_bank_reg;
        end
      end
    end
  end

  // Commit and ack in the same cycle can never target the same bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic            full_reg;
    logic [LENW-1:0] len_reg;

    always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
        full_reg <= 1'b0;
        len_reg  <= '0;
      end else if (bus.bsm_flush) begin
        full_reg <= 1'b0;
      end else if (commit_ok && (wr_bank_reg == 1'(gi))) begin
        full_reg <= 1'b1;
        len_reg  <= bus.lnctrl_len;
      end else if (ack_ok && (rd_bank_reg == 1'(gi))) begin
        full_reg <= 1'b0;
      end
    end

    assign full[gi]     = full_reg;
    assign bank_len[gi] = len_reg;
  end

  assign bus.lnctrl_wready   = wready;
  assign bus.lnctrl_bufavail = bufavail;
  assign bus.lnctrl_ovf      = ovf_reg;
  assign bus.bsm_dout_valid  = dout_valid_reg;
  assign bus.bsm_pkt_valid   = full[rd_bank_reg];
  assign bus.bsm_pkt_len     = full[rd_bank_reg] ? bank_len[rd_bank_reg] : '0;
endmodule

// File: tb/tb_pytxaclbufctrl.sv
// Directed bench for pytxaclbufctrl: read data checked by a scoreboard, flags checked inline.
module tb_pytxaclbufctrl;
  import pytxaclbufctrl_pkg::*;

  logic clk_6M;
  logic rstz;
  int   n_vec;
  int   n_bad;
  logic [DW-1:0] exp_q [$];

  pytxaclbufctrl_if bus ();

  pytxaclbufctrl dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .bus    (bus)
  );

  initial clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every valid read word is matched against the oldest expectation.
  always @(negedge clk_6M) begin
    if (bus.bsm_dout_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got %08h, required no read data", bus.bsm_dout);
      end else begin
        automatic logic [DW-1:0] e = exp_q.pop_front();
        if (bus.bsm_dout !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %08h, required %08h", bus.bsm_dout, e);
        end else begin
          $display("rd data=%08h ok", bus.bsm_dout);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic av, input logic wr, input logic pv,
                           input logic [LENW-1:0] pl, input logic ov);
    chk({tag, "_bufavail"}, 32'(bus.lnctrl_bufavail), 32'(av));
    chk({tag, "_wready"},   32'(bus.lnctrl_wready),   32'(wr));
    chk({tag, "_pkt_valid"}, 32'(bus.bsm_pkt_valid),  32'(pv));
    chk({tag, "_pkt_len"},  32'(bus.bsm_pkt_len),     32'(pl));
    chk({tag, "_ovf"},      32'(bus.lnctrl_ovf),      32'(ov));
  endtask

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic wr_word(input logic [DW-1:0] d, input logic exp_rdy);
    bus.lnctrl_wr    = 1'b1;
    bus.lnctrl_wdata = d;
    #1;
    chk("wr_wready", 32'(bus.lnctrl_wready), 32'(exp_rdy));
    step();
    bus.lnctrl_wr = 1'b0;
  endtask

  task automatic commit(input logic [LENW-1:0] len);
    bus.lnctrl_commit = 1'b1;
    bus.lnctrl_len    = len;
    step();
    bus.lnctrl_commit = 1'b0;
    $display("commit len=%0d", len);
  endtask

  task automatic ack();
    bus.bsm_ack = 1'b1;
    step();
    bus.bsm_ack = 1'b0;
  endtask

  task automatic rd(input logic [AW-2:0] addr, input logic [DW-1:0] exp);
    bus.bsm_rd   = 1'b1;
    bus.bsm_addr = addr;
    exp_q.push_back(exp);
    step();
    bus.bsm_rd = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    bus.lnctrl_wr     = 1'b0;
    bus.lnctrl_wdata  = '0;
    bus.lnctrl_commit = 1'b0;
    bus.lnctrl_len    = '0;
    bus.bsm_rd        = 1'b0;
    bus.bsm_addr      = '0;
    bus.bsm_ack       = 1'b0;
    bus.bsm_flush     = 1'b0;
    rstz = 1'b0;
    repeat (2) @(posedge clk_6M);
    #1;
    rstz = 1'b1;
    chk_flags("reset", 1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
    chk("reset_dout_valid", 32'(bus.bsm_dout_valid), 32'd0);

    // Basic packet into bank0, then read twice without ack (retransmit).
    wr_word(32'hA000_0000, 1'b1);
    wr_word(32'hA000_0001, 1'b1);
    wr_word(32'hA000_0002, 1'b1);
    commit(10'd12);
    chk_flags("pkt0", 1'b1, 1'b1, 1'b1, 10'd12, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      rd(7'd0, 32'hA000_0000);
      rd(7'd1, 32'hA000_0001);
      rd(7'd2, 32'hA000_0002);
    end
    step();
    chk_flags("retx", 1'b1, 1'b1, 1'b1, 10'd12, 1'b0);

    // Fill bank1: both full, extra commit and write are ignored.
    wr_word(32'hB000_0000, 1'b1);
    wr_word(32'hB000_0001, 1'b1);
    commit(10'd8);
    chk_flags("both_full", 1'b0, 1'b0, 1'b1, 10'd12, 1'b0);
    commit(10'd99);
    chk_flags("commit_ign", 1'b0, 1'b0, 1'b1, 10'd12, 1'b0);
    wr_word(32'hBAD0_0000, 1'b0);
    ack();
    chk_flags("ack0", 1'b1, 1'b1, 1'b1, 10'd8, 1'b0);
    rd(7'd0, 32'hB000_0000);
    rd(7'd1, 32'hB000_0001);

    // Read/write collision: read wins, write retried next cycle lands at offset 0.
    bus.bsm_rd       = 1'b1;
    bus.bsm_addr     = 7'd0;
    bus.lnctrl_wr    = 1'b1;
    bus.lnctrl_wdata = 32'hC000_0000;
    exp_q.push_back(32'hB000_0000);
    #1;
    chk("collide_wready", 32'(bus.lnctrl_wready), 32'd0);
    step();
    bus.bsm_rd = 1'b0;
    #1;
    chk("retry_wready", 32'(bus.lnctrl_wready), 32'd1);
    step();
    bus.lnctrl_wr = 1'b0;
    wr_word(32'hC000_0001, 1'b1);

    // Commit bank0 and ack bank1 in the same cycle.
    bus.lnctrl_commit = 1'b1;
    bus.lnctrl_len    = 10'd5;
    bus.bsm_ack       = 1'b1;
    step();
    bus.lnctrl_commit = 1'b0;
    bus.bsm_ack       = 1'b0;
    chk_flags("commit_ack", 1'b1, 1'b1, 1'b1, 10'd5, 1'b0);
    rd(7'd0, 32'hC000_0000);
    rd(7'd1, 32'hC000_0001);

    // Overflow in bank1: 128 words fit, the 129th is dropped.
    for (int i = 0; i < BANK_WORDS; i++) begin
      wr_word(32'hD000_0000 | 32'(i), 1'b1);
    end
    chk("ovf_set", 32'(bus.lnctrl_ovf), 32'd1);
    chk("ovf_wready", 32'(bus.lnctrl_wready), 32'd0);
    wr_word(32'hDEAD_0080, 1'b0);
    ack();
    chk_flags("ovf_ack", 1'b1, 1'b0, 1'b0, 10'd0, 1'b1);
    commit(10'(MAX_ACL_BYTES));
    chk_flags("ovf_commit", 1'b1, 1'b1, 1'b1, 10'(MAX_ACL_BYTES), 1'b0);
    rd(7'd0,   32'hD000_0000);
    rd(7'd64,  32'hD000_0040);
    rd(7'd127, 32'hD000_007F);

    // Flush mid-write with commit/ack/write in the same cycle.
    wr_word(32'hE000_0000, 1'b1);
    bus.bsm_flush     = 1'b1;
    bus.lnctrl_wr     = 1'b1;
    bus.lnctrl_wdata  = 32'hE000_0001;
    bus.lnctrl_commit = 1'b1;
    bus.lnctrl_len    = 10'd9;
    bus.bsm_ack       = 1'b1;
    step();
    bus.bsm_flush     = 1'b0;
    bus.lnctrl_wr     = 1'b0;
    bus.lnctrl_commit = 1'b0;
    bus.bsm_ack       = 1'b0;
    chk_flags("flush", 1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
    ack();
    chk_flags("ack_ign", 1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
    wr_word(32'hF000_0000, 1'b1);
    commit(10'd4);
    chk_flags("post_flush", 1'b1, 1'b1, 1'b1, 10'd4, 1'b0);
    rd(7'd0, 32'hF000_0000);

    // Asynchronous reset mid-packet while read data is still presented.
    wr_word(32'h6000_0000, 1'b1);
    rd(7'd0, 32'hF000_0000);
    #5;
    rstz = 1'b0;
    #1;
    chk_flags("rstz_mid", 1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
    chk("rstz_dout_valid", 32'(bus.bsm_dout_valid), 32'd0);
    step();
    rstz = 1'b1;
    wr_word(32'h7000_0000, 1'b1);
    commit(10'd7);
    chk_flags("post_rst", 1'b1, 1'b1, 1'b1, 10'd7, 1'b0);
    rd(7'd0, 32'h7000_0000);

    // Zero-word commit is a valid length-only packet.
    commit(10'd0);
    chk_flags("zero_commit", 1'b0, 1'b0, 1'b1, 10'd7, 1'b0);
    ack();
    chk_flags("zero_pkt", 1'b1, 1'b1, 1'b1, 10'd0, 1'b0);

    repeat (3) step();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
